mem_port_arb: RTL

Sequencer and arbiter for the single data-memory port shared by the store queue's commit-drain path and the load unit. Accepts one request per transaction from either side, drives a valid/ready memory request, tracks the outstanding load until its read data returns, and forwards that data to the load unit tagged with its ROB index. Committed stores are never dropped. In-flight load responses are discarded on a pipeline flush.

---
 rtl/mem_port_arb.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arb.sv
// Arbiter/sequencer for the shared data-memory port (store drain vs. load unit).
// Optional feature macro: MEM_ARB_STARVE_EN enables the store anti-starvation counter.
module mem_port_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ROB_W      = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_req_valid,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [DATA_W-1:0] st_req_data,
    output logic              st_req_ready,
    input  logic              sq_full,
    input  logic              ld_req_valid,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [ROB_W-1:0]  ld_req_rob,
    output logic              ld_req_ready,
    output logic              ld_resp_valid,
    output logic [ROB_W-1:0]  ld_resp_rob,
    output logic [DATA_W-1:0] ld_resp_data,
    input  logic              flush,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t             state;
    logic               is_load;
    logic               kill;
    logic [ROB_W-1:0]   req_rob;
    logic               st_prio;
    logic               st_grant;
    logic               ld_grant;

`ifdef MEM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_cnt;

    assign st_prio = sq_full || (starve_cnt == STARVE_LIM);

    // Saturating count of loads granted while a store was waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (st_grant) begin
            starve_cnt <= 4'd0;
        end else if (ld_grant && st_req_valid && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= starve_cnt;
        end
    end
`else
    assign st_prio = sq_full;
`endif

    // IDLE arbitration; a flushing cycle can never accept a load
    always_comb begin
        st_grant = 1'b0;
        ld_grant = 1'b0;
        if ((state == IDLE) && !rst) begin
            if (st_req_valid && (!ld_req_valid || flush || st_prio)) begin
                st_grant = 1'b1;
            end else if (ld_req_valid && !flush) begin
                ld_grant = 1'b1;
            end else begin
                st_grant = 1'b0;
                ld_grant = 1'b0;
            end
        end else begin
            st_grant = 1'b0;
            ld_grant = 1'b0;
        end
    end

    assign st_req_ready = st_grant;
    assign ld_req_ready = ld_grant;

    // Transaction FSM with registered memory-request and load-response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            is_load       <= 1'b0;
            kill          <= 1'b0;
            req_rob       <= {ROB_W{1'b0}};
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= {ADDR_W{1'b0}};
            mem_req_wdata <= {DATA_W{1'b0}};
            ld_resp_valid <= 1'b0;
            ld_resp_rob   <= {ROB_W{1'b0}};
            ld_resp_data  <= {DATA_W{1'b0}};
        end else begin
            ld_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    kill <= 1'b0;
                    if (st_grant) begin
                        state         <= ISSUE;
                        is_load       <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b1;
                        mem_req_addr  <= st_req_addr;
                        mem_req_wdata <= st_req_data;
                    end else if (ld_grant) begin
                        state         <= ISSUE;
                        is_load       <= 1'b1;
                        req_rob       <= ld_req_rob;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= ld_req_addr;
                        mem_req_wdata <= {DATA_W{1'b0}};
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (is_load && flush) begin
                        kill <= 1'b1;
                    end else begin
                        kill <= kill;
                    end
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= is_load ? WAIT_RD : IDLE;
                    end else begin
                        state <= ISSUE;
                    end
                end
                WAIT_RD: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                        kill  <= 1'b0;
                        // A flush landing on the response cycle also squashes it
                        if (!kill && !flush) begin
                            ld_resp_valid <= 1'b1;
                            ld_resp_rob   <= req_rob;
                            ld_resp_data  <= mem_resp_rdata;
                        end else begin
                            ld_resp_valid <= 1'b0;
                        end
                    end else if (flush) begin
                        kill <= 1'b1;
                    end else begin
                        state <= WAIT_RD;
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                    kill          <= 1'b0;
                end
            endcase
        end
    end

endmodule
